// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : dmem_port_arbiter                                             |
// | Description: Serialises slot A then slot B onto the single data-memory     |
// |              port; optional store-to-load forwarding via DMEM_ARB_FWD_EN.  |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                req_valid_a,
  input  logic                req_re_a,
  input  logic [DATA_W/8-1:0] req_we_a,
  input  logic [ADDR_W-1:0]   req_addr_a,
  input  logic [DATA_W-1:0]   req_wdata_a,
  input  logic                req_valid_b,
  input  logic                req_re_b,
  input  logic [DATA_W/8-1:0] req_we_b,
  input  logic [ADDR_W-1:0]   req_addr_b,
  input  logic [DATA_W-1:0]   req_wdata_b,
  output logic                done_a,
  output logic                done_b,
  output logic [DATA_W-1:0]   rdata_a,
  output logic [DATA_W-1:0]   rdata_b,
  output logic                stall,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_we,
  output logic                dmem_re,
  input  logic [DATA_W-1:0]   dmem_rdata
);

  localparam int c_be_w = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACC_A = 3'd1,
    RSP_A = 3'd2,
    ACC_B = 3'd3,
    RSP_B = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_a_load;
  logic                r_b_load;
  logic [c_be_w-1:0]   r_b_we;
  logic [ADDR_W-1:0]   r_b_addr;
  logic [DATA_W-1:0]   r_b_wdata;
  logic                r_b_pend;
  logic                w_ld_a;
  logic                w_ld_b;
  logic                w_b_take;
  logic                w_fwd;
`ifdef DMEM_ARB_FWD_EN
  logic [DATA_W-1:0]   r_a_wdata;
  logic                r_b_fwd;
`endif

  // A store with any byte enable wins over a simultaneous read request.
  assign w_ld_a   = req_re_a & ~|req_we_a;
  assign w_ld_b   = req_re_b & ~|req_we_b;
  assign w_b_take = req_valid_b & ~flush;

`ifdef DMEM_ARB_FWD_EN
  assign w_fwd = req_valid_a & w_b_take & (req_we_a == {c_be_w{1'b1}}) & w_ld_b &
                 (req_addr_a[ADDR_W-1:2] == req_addr_b[ADDR_W-1:2]);
`else
  assign w_fwd = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_we    <= '0;
      dmem_re    <= 1'b0;
      r_a_load   <= 1'b0;
      r_b_load   <= 1'b0;
      r_b_we     <= '0;
      r_b_addr   <= '0;
      r_b_wdata  <= '0;
      r_b_pend   <= 1'b0;
`ifdef DMEM_ARB_FWD_EN
      r_a_wdata  <= '0;
      r_b_fwd    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      dmem_we <= '0;
      dmem_re <= 1'b0;
      case (r_state)
        IDLE: begin
          r_a_load  <= w_ld_a;
          r_b_load  <= w_ld_b;
          r_b_we    <= req_we_b;
          r_b_addr  <= req_addr_b;
          r_b_wdata <= req_wdata_b;
          r_b_pend  <= req_valid_a & w_b_take & ~w_fwd;
`ifdef DMEM_ARB_FWD_EN
          r_a_wdata <= req_wdata_a;
          r_b_fwd   <= w_fwd;
`endif
          if (req_valid_a) begin
            dmem_addr  <= req_addr_a;
            dmem_wdata <= req_wdata_a;
            dmem_we    <= req_we_a;
            dmem_re    <= w_ld_a;
          end else if (w_b_take) begin
            dmem_addr  <= req_addr_b;
            dmem_wdata <= req_wdata_b;
            dmem_we    <= req_we_b;
            dmem_re    <= w_ld_b;
          end
        end
        ACC_A: begin
          // B has not touched memory yet, so a flush here still drops it.
          if (flush) begin
            r_b_pend <= 1'b0;
`ifdef DMEM_ARB_FWD_EN
            r_b_fwd  <= 1'b0;
`endif
          end
        end
        RSP_A: begin
          r_b_pend <= 1'b0;
`ifdef DMEM_ARB_FWD_EN
          r_b_fwd  <= 1'b0;
`endif
          if (r_b_pend && !flush) begin
            dmem_addr  <= r_b_addr;
            dmem_wdata <= r_b_wdata;
            dmem_we    <= r_b_we;
            dmem_re    <= r_b_load;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid_a)   w_state_nxt = ACC_A;
        else if (w_b_take) w_state_nxt = ACC_B;
      end
      ACC_A:   w_state_nxt = RSP_A;
      RSP_A:   w_state_nxt = (r_b_pend && !flush) ? ACC_B : IDLE;
      ACC_B:   w_state_nxt = RSP_B;
      RSP_B:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done_a  = (r_state == RSP_A);
    rdata_a = (done_a && r_a_load) ? dmem_rdata : '0;
    done_b  = (r_state == RSP_B);
    rdata_b = (done_b && r_b_load) ? dmem_rdata : '0;
`ifdef DMEM_ARB_FWD_EN
    if (r_state == RSP_A && r_b_fwd && !flush) begin
      done_b  = 1'b1;
      rdata_b = r_a_wdata;
    end
`endif
    stall = 1'b0;
    case (r_state)
      // Gated by reset so the issue unit sees no stall while the block is held.
      IDLE:         stall = reset & (req_valid_a | req_valid_b);
      ACC_A, ACC_B: stall = 1'b1;
      RSP_A:        stall = r_b_pend & ~flush;
      default:      stall = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// Bench for dmem_port_arbiter: per-transaction timeline model plus memory image.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        req_valid_a, req_re_a, req_valid_b, req_re_b;
  logic [3:0]  req_we_a, req_we_b;
  logic [31:0] req_addr_a, req_wdata_a, req_addr_b, req_wdata_b;
  logic        done_a, done_b, stall, dmem_re;
  logic [31:0] rdata_a, rdata_b, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_we;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid_a(req_valid_a), .req_re_a(req_re_a), .req_we_a(req_we_a),
    .req_addr_a(req_addr_a), .req_wdata_a(req_wdata_a),
    .req_valid_b(req_valid_b), .req_re_b(req_re_b), .req_we_b(req_we_b),
    .req_addr_b(req_addr_b), .req_wdata_b(req_wdata_b),
    .done_a(done_a), .done_b(done_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .stall(stall), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .dmem_rdata(dmem_rdata)
  );

  // Synchronous memory: read data appears the cycle after dmem_re.
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  always @(posedge clk) begin
    if (dmem_re) dmem_rdata <= mem[dmem_addr[11:2]];
    for (int i = 0; i < 4; i++)
      if (dmem_we[i]) mem[dmem_addr[11:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected timeline of one transaction, indexed by cycle offset from the request.
  logic        e_done_a [5];
  logic        e_done_b [5];
  logic        e_stall  [5];
  logic        e_re     [5];
  logic [3:0]  e_we     [5];
  logic [31:0] e_addr   [5];
  logic [31:0] e_wd     [5];
  logic [31:0] e_ra, e_rb;
  int          e_end;
  int          cur_k = 0;
  bit          active = 1'b0;
  int          o_done_a_k, o_done_b_k, o_acc;
  logic [31:0] o_ra, o_rb;

  function automatic int widx(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  task automatic mem_store(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      if (we[i]) ref_mem[widx(a)][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic predict(input bit va, input bit ra, input logic [3:0] wa,
                         input logic [31:0] aa, input logic [31:0] da,
                         input bit vb, input bit rb, input logic [3:0] wb,
                         input logic [31:0] ab, input logic [31:0] db, input int f);
    bit la, lb, fwd, blive;
    la = ra && (wa == 4'h0);
    lb = rb && (wb == 4'h0);
    for (int k = 0; k < 5; k++) begin
      e_done_a[k] = 0; e_done_b[k] = 0; e_stall[k] = 0; e_re[k] = 0;
      e_we[k] = 4'h0; e_addr[k] = 32'h0; e_wd[k] = 32'h0;
    end
    e_ra = 32'h0; e_rb = 32'h0; e_end = 0;
    if (va) begin
      fwd = 1'b0;
`ifdef DMEM_ARB_FWD_EN
      fwd = vb && (wa == 4'hF) && lb && (aa[31:2] == ab[31:2]);
`endif
      blive = vb && !(f >= 0 && f <= 2);
      e_stall[0] = 1; e_stall[1] = 1;
      e_we[1] = wa; e_re[1] = la; e_addr[1] = aa; e_wd[1] = da;
      e_ra = la ? ref_mem[widx(aa)] : 32'h0;
      mem_store(aa, wa, da);
      e_done_a[2] = 1; e_end = 2;
      if (blive && fwd) begin
        e_done_b[2] = 1; e_rb = da;
      end else if (blive) begin
        e_stall[2] = 1; e_stall[3] = 1;
        e_we[3] = wb; e_re[3] = lb; e_addr[3] = ab; e_wd[3] = db;
        e_rb = lb ? ref_mem[widx(ab)] : 32'h0;
        mem_store(ab, wb, db);
        e_done_b[4] = 1; e_end = 4;
      end
    end else if (vb) begin
      e_stall[0] = 1; e_stall[1] = 1;
      e_we[1] = wb; e_re[1] = lb; e_addr[1] = ab; e_wd[1] = db;
      e_rb = lb ? ref_mem[widx(ab)] : 32'h0;
      mem_store(ab, wb, db);
      e_done_b[2] = 1; e_end = 2;
    end
  endtask

  always @(negedge clk) begin
    if (active) begin
      if (cur_k == 0) begin
        o_done_a_k = -1; o_done_b_k = -1; o_acc = 0; o_ra = 32'h0; o_rb = 32'h0;
      end
      chk("done_a", done_a, e_done_a[cur_k]);
      chk("done_b", done_b, e_done_b[cur_k]);
      chk("stall", stall, e_stall[cur_k]);
      chk("dmem_we", dmem_we, e_we[cur_k]);
      chk("dmem_re", dmem_re, e_re[cur_k]);
      if (e_re[cur_k] || e_we[cur_k] != 4'h0) chk("dmem_addr", dmem_addr, e_addr[cur_k]);
      if (e_we[cur_k] != 4'h0) chk("dmem_wdata", dmem_wdata, e_wd[cur_k]);
      if (done_a) begin o_done_a_k = cur_k; o_ra = rdata_a; chk("rdata_a", rdata_a, e_ra); end
      if (done_b) begin o_done_b_k = cur_k; o_rb = rdata_b; chk("rdata_b", rdata_b, e_rb); end
      if (dmem_re || dmem_we != 4'h0) o_acc++;
    end
  end

  // Called just after a rising edge with the DUT idle; holds requests until done.
  task automatic run_txn(input bit va, input bit ra, input logic [3:0] wa,
                         input logic [31:0] aa, input logic [31:0] da,
                         input bit vb, input bit rb, input logic [3:0] wb,
                         input logic [31:0] ab, input logic [31:0] db, input int f);
    predict(va, ra, wa, aa, da, vb, rb, wb, ab, db, f);
    req_valid_a = va; req_re_a = ra; req_we_a = wa; req_addr_a = aa; req_wdata_a = da;
    req_valid_b = vb; req_re_b = rb; req_we_b = wb; req_addr_b = ab; req_wdata_b = db;
    flush = (f == 0); cur_k = 0; active = 1'b1;
    for (int k = 1; k <= e_end; k++) begin
      @(posedge clk); #1;
      cur_k = k; flush = (f == k);
    end
    @(posedge clk); #1;
    active = 1'b0; flush = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA500_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
    end
    mem[32'h100 >> 2] = 32'hDEAD_BEEF; ref_mem[32'h100 >> 2] = 32'hDEAD_BEEF;
    mem[32'h300 >> 2] = 32'h0BAD_F00D; ref_mem[32'h300 >> 2] = 32'h0BAD_F00D;

    reset = 1'b0; flush = 1'b0;
    req_valid_a = 1'b1; req_re_a = 1'b1; req_we_a = 4'h0; req_addr_a = 32'h100; req_wdata_a = 32'h0;
    req_valid_b = 1'b0; req_re_b = 1'b0; req_we_b = 4'h0; req_addr_b = 32'h0; req_wdata_b = 32'h0;
    #2;
    chk("rst_stall", stall, 1'b0);
    chk("rst_done_a", done_a, 1'b0);
    chk("rst_done_b", done_b, 1'b0);
    chk("rst_dmem_re", dmem_re, 1'b0);
    chk("rst_dmem_we", dmem_we, 4'h0);
    req_valid_a = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // Reset asserted in the middle of an A access.
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    chk("acc_a_re", dmem_re, 1'b1);
    reset = 1'b0; #1;
    chk("midrst_re", dmem_re, 1'b0);
    chk("midrst_we", dmem_we, 4'h0);
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_done_a", done_a, 1'b0);
    req_valid_a = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("post_rst_done_a", done_a, 1'b0);
    chk("post_rst_stall", stall, 1'b0);
    @(posedge clk); #1;

    run_txn(1, 1, 4'h0, 32'h100, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, -1);
    chk("t2_done_k", o_done_a_k, 2);
    chk("t2_rdata", o_ra, 32'hDEAD_BEEF);

    run_txn(1, 0, 4'b0011, 32'h200, 32'hCAFE_1234, 1, 1, 4'h0, 32'h300, 32'h0, -1);
    chk("t3_done_a_k", o_done_a_k, 2);
    chk("t3_done_b_k", o_done_b_k, 4);
    chk("t3_rdata_b", o_rb, 32'h0BAD_F00D);
    chk("t3_mem", mem[32'h200 >> 2][15:0], 16'h1234);

    run_txn(1, 0, 4'b0011, 32'h200, 32'h0000_5678, 1, 1, 4'h0, 32'h300, 32'h0, 2);
    chk("t4_done_b_k", o_done_b_k, -1);
    chk("t4_acc", o_acc, 1);
    chk("t4_mem", mem[32'h200 >> 2][15:0], 16'h5678);

    run_txn(1, 0, 4'hF, 32'h400, 32'h1234_5678, 1, 1, 4'h0, 32'h402, 32'h0, -1);
    chk("t5_rdata_b", o_rb, 32'h1234_5678);
`ifdef DMEM_ARB_FWD_EN
    chk("t5_done_b_k", o_done_b_k, 2);
    chk("t5_acc", o_acc, 1);
`else
    chk("t5_done_b_k", o_done_b_k, 4);
    chk("t5_acc", o_acc, 2);
`endif

    run_txn(0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 4'hF, 32'h500, 32'hA5A5_A5A5, -1);
    chk("t6_done_b_k", o_done_b_k, 2);
    chk("t6_done_a_k", o_done_a_k, -1);

    for (int n = 0; n < 400; n++) begin
      bit va, vb, ra, rb;
      logic [3:0]  wa, wb;
      logic [31:0] aa, ab, da, db;
      int f, ka, kb;
      va = ($urandom % 4) != 0;
      vb = ($urandom % 3) != 0;
      ka = $urandom % 5; kb = $urandom % 5;
      ra = (ka == 0) || (ka == 4);
      wa = (ka == 1) ? 4'hF : (ka == 2 || ka == 4) ? 4'($urandom_range(1, 15)) : 4'h0;
      rb = (kb == 0) || (kb == 4);
      wb = (kb == 1) ? 4'hF : (kb == 2 || kb == 4) ? 4'($urandom_range(1, 15)) : 4'h0;
      aa = 32'($urandom % 64);
      ab = ($urandom % 2) ? {aa[31:2], 2'($urandom % 4)} : 32'($urandom % 64);
      da = $urandom; db = $urandom;
      f = ($urandom % 8 < 5) ? int'($urandom % 5) : -1;
      if (!va && vb && f == 0) f = -1;
      run_txn(va, ra, wa, aa, da, vb, rb, wb, ab, db, f);
    end

    begin
      int bad;
      bad = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk("mem_image", bad, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
